// File: rtl/writeback_regfile.sv
// Write-back mux, 32-entry integer register file (x0 hardwired to zero) and committed-write counter.
// Optional macro REGFILE_BYPASS_EN: same-cycle write-to-read bypass on both read ports.
module writeback_regfile #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] wb_address,
  input  logic [DATA_WIDTH-1:0] wb_value,
  input  logic [4:0]            wb_rd,
  input  logic                  wb_memToReg,
  input  logic                  wb_regWrite,
  input  logic [4:0]            rs1,
  input  logic [4:0]            rs2,
  output logic [DATA_WIDTH-1:0] rs1_data,
  output logic [DATA_WIDTH-1:0] rs2_data,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic [63:0]           write_count
);

  // No handshake: a write is taken on every edge where wb_regWrite is high,
  // wb_rd is non-zero and reset is low; there is no backpressure.
  logic [DATA_WIDTH-1:0] regs [32];
  logic                  wr_accept;

  assign wb_data   = wb_memToReg ? wb_value : wb_address;
  assign wr_accept = wb_regWrite && (wb_rd != 5'd0) && !reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
      write_count <= '0;
    end else if (wr_accept) begin
      regs[wb_rd] <= wb_data;
      write_count <= write_count + 64'd1;
    end
  end

  // Entry 0 is cleared by reset and never written, but reads of x0 are forced to zero anyway.
  always_comb begin
    rs1_data = '0;
    if (rs1 != 5'd0) rs1_data = regs[rs1];
`ifdef REGFILE_BYPASS_EN
    if (wr_accept && (wb_rd == rs1)) rs1_data = wb_data;
`endif
  end

  always_comb begin
    rs2_data = '0;
    if (rs2 != 5'd0) rs2_data = regs[rs2];
`ifdef REGFILE_BYPASS_EN
    if (wr_accept && (wb_rd == rs2)) rs2_data = wb_data;
`endif
  end

endmodule
